dense_argmax: RTL and testbench

DENSE_ARGMAX -- requirements
Module: dense_argmax

---
 rtl/bnn_pkg.sv | 33 +++
 rtl/dense_argmax_popcount.sv | 26 ++
 rtl/dense_argmax.sv | 167 ++++++++++++++++
 tb/tb_dense_argmax.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared FSM states, default sizes and width helpers
// for the binary dense layer with argmax.
package bnn_pkg;

   localparam int DEF_IC       = 8;
   localparam int DEF_IMG_SIZE = 14;
   localparam int DEF_NC       = 10;
   localparam int DEF_CHUNK    = 64;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      COMPARE,
      DONE
   } state_e;

   function automatic int feat_w(input int ic, input int img);
      return ic * img * img;
   endfunction

   function automatic int nchunk(input int fw, input int chunk);
      return (fw + chunk - 1) / chunk;
   endfunction

   function automatic int score_w(input int fw);
      return $clog2(fw + 1) + 1;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dense_argmax_popcount.sv
// ChunkPopcount: combinational XNOR, pad mask and popcount
// over one CHUNK-bit slice of the feature vector.
module ChunkPopcount
   import bnn_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK,
   parameter int PW    = $clog2(CHUNK + 1)
) (
   input  logic [CHUNK-1:0] feat_i,
   input  logic [CHUNK-1:0] wt_i,
   input  logic [CHUNK-1:0] mask_i,
   output logic [PW-1:0]    pop_o
);

   logic [CHUNK-1:0] hit;

   assign hit = mask_i & ~(feat_i ^ wt_i);

   always_comb begin
      pop_o = '0;
      for (int i = 0; i < CHUNK; i++) begin
         pop_o = pop_o + PW'(hit[i]);
      end
   end

endmodule

// File: rtl/dense_argmax.sv
// dense_argmax: chunk-serial binary dense layer with argmax.
// Define DENSE_ARGMAX_BIAS_EN to add a signed per-class bias.
module dense_argmax
   import bnn_pkg::*;
#(
   parameter int  IC       = DEF_IC,
   parameter int  IMG_SIZE = DEF_IMG_SIZE,
   parameter int  NC       = DEF_NC,
   parameter int  CHUNK    = DEF_CHUNK,
   localparam int FEAT_W   = feat_w(IC, IMG_SIZE),
   localparam int SW       = score_w(FEAT_W),
   localparam int CW       = idx_w(NC)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          data_in_ready,
   input  logic [IMG_SIZE*IMG_SIZE-1:0]  img_in [0:IC-1],
   input  logic [FEAT_W-1:0]             weights [0:NC-1],
`ifdef DENSE_ARGMAX_BIAS_EN
   input  logic signed [7:0]             bias [0:NC-1],
`endif
   output logic [CW-1:0]                 class_out,
   output logic signed [SW-1:0]          score_out,
   output logic                          data_out_ready
);

   localparam int P      = IMG_SIZE * IMG_SIZE;
   localparam int NCHUNK = nchunk(FEAT_W, CHUNK);
   localparam int PADW   = NCHUNK * CHUNK;
   localparam int BW     = idx_w(PADW);
   localparam int KW     = idx_w(NCHUNK);
   localparam int AW     = SW - 1;
   localparam int PW     = $clog2(CHUNK + 1);

   state_e               state_q;
   logic [KW-1:0]        chunk_q;
   logic [CW-1:0]        class_q;
   logic [AW-1:0]        acc_q;
   logic signed [SW-1:0] best_q;
   logic [CW-1:0]        best_cls_q;
   logic [CW-1:0]        cls_out_q;
   logic signed [SW-1:0] score_q;
   logic                 rdy_q;

   logic [PADW-1:0]      feat_pad;
   logic [PADW-1:0]      wt_pad;
   logic [BW-1:0]        base;
   logic [CHUNK-1:0]     mask;
   logic [CHUNK-1:0]     feat_c;
   logic [CHUNK-1:0]     wt_c;
   logic [PW-1:0]        pop;
   logic signed [SW-1:0] score;
   logic                 last_chunk;
   logic                 last_class;
   logic                 take;

   always_comb begin
      feat_pad = '0;
      for (int oc = 0; oc < IC; oc++) begin
         feat_pad[oc*P +: P] = img_in[oc];
      end
      wt_pad = '0;
      wt_pad[FEAT_W-1:0] = weights[class_q];
   end

   assign base   = BW'(chunk_q) * BW'(CHUNK);
   assign feat_c = feat_pad[base +: CHUNK];
   assign wt_c   = wt_pad[base +: CHUNK];

   // Padding past FEAT_W would XNOR to 1, so it must never count.
   always_comb begin
      mask = '0;
      for (int i = 0; i < CHUNK; i++) begin
         mask[i] = (int'(base) + i) < FEAT_W;
      end
   end

   ChunkPopcount #(
      .CHUNK (CHUNK),
      .PW    (PW)
   ) u_pop (
      .feat_i (feat_c),
      .wt_i   (wt_c),
      .mask_i (mask),
      .pop_o  (pop)
   );

   always_comb begin
`ifdef DENSE_ARGMAX_BIAS_EN
      score = $signed({1'b0, acc_q}) + SW'(bias[class_q]);
`else
      score = $signed({1'b0, acc_q});
`endif
   end

   assign last_chunk = chunk_q == KW'(NCHUNK - 1);
   assign last_class = class_q == CW'(NC - 1);
   assign take       = (class_q == '0) || (score > best_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         chunk_q    <= '0;
         class_q    <= '0;
         acc_q      <= '0;
         best_q     <= '0;
         best_cls_q <= '0;
         cls_out_q  <= '0;
         score_q    <= '0;
         rdy_q      <= 1'b0;
      end else if (!data_in_ready) begin
         state_q    <= IDLE;
         chunk_q    <= '0;
         class_q    <= '0;
         acc_q      <= '0;
         best_q     <= '0;
         best_cls_q <= '0;
         cls_out_q  <= '0;
         score_q    <= '0;
         rdy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_q    <= ACCUM;
               chunk_q    <= '0;
               class_q    <= '0;
               acc_q      <= '0;
               best_q     <= '0;
               best_cls_q <= '0;
            end
            ACCUM: begin
               acc_q <= acc_q + AW'(pop);
               if (last_chunk) begin
                  chunk_q <= '0;
                  state_q <= COMPARE;
               end else begin
                  chunk_q <= chunk_q + 1'b1;
               end
            end
            COMPARE: begin
               if (take) begin
                  best_q     <= score;
                  best_cls_q <= class_q;
               end
               acc_q <= '0;
               if (last_class) begin
                  state_q <= DONE;
               end else begin
                  class_q <= class_q + 1'b1;
                  state_q <= ACCUM;
               end
            end
            DONE: begin
               rdy_q     <= 1'b1;
               cls_out_q <= best_cls_q;
               score_q   <= best_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign class_out      = cls_out_q;
   assign score_out      = score_q;
   assign data_out_ready = rdy_q;

endmodule

// File: tb/tb_dense_argmax.sv
// tb_dense_argmax: table, hand-sequence and random checks of
// dense_argmax against a bit-level argmax model.
module tb_dense_argmax;

   localparam int IC    = 8;
   localparam int IMG   = 14;
   localparam int NC    = 10;
   localparam int CHUNK = 64;
   localparam int P     = IMG * IMG;
   localparam int FW    = IC * P;
   localparam int SW    = $clog2(FW + 1) + 1;
   localparam int CW    = $clog2(NC);
   localparam int LAT   = 261;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 din = 1'b0;
   logic [P-1:0]         img [0:IC-1];
   logic [FW-1:0]        wts [0:NC-1];
   logic signed [7:0]    bias_v [0:NC-1];
   logic [CW-1:0]        cls_o;
   logic signed [SW-1:0] score_o;
   logic                 dout_rdy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string name;
      bit    ffill;
      bit    wfill;
      int    srow;
      bit    sfill;
      int    ecls;
      int    escore;
   } vec_t;

   vec_t vecs[$];

   dense_argmax #(
      .IC       (IC),
      .IMG_SIZE (IMG),
      .NC       (NC),
      .CHUNK    (CHUNK)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in_ready  (din),
      .img_in         (img),
      .weights        (wts),
`ifdef DENSE_ARGMAX_BIAS_EN
      .bias           (bias_v),
`endif
      .class_out      (cls_o),
      .score_out      (score_o),
      .data_out_ready (dout_rdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fill(input bit ff, input bit wf, input int srow,
                       input bit sf);
      for (int oc = 0; oc < IC; oc++) img[oc] = {P{ff}};
      for (int c = 0; c < NC; c++) begin
         wts[c]    = (c == srow) ? {FW{sf}} : {FW{wf}};
         bias_v[c] = '0;
      end
   endtask

   task automatic fill_rand();
      for (int oc = 0; oc < IC; oc++)
         for (int b = 0; b < P; b++) img[oc][b] = 1'($urandom);
      for (int c = 0; c < NC; c++) begin
         for (int b = 0; b < FW; b++) wts[c][b] = 1'($urandom);
`ifdef DENSE_ARGMAX_BIAS_EN
         bias_v[c] = 8'($urandom);
`else
         bias_v[c] = '0;
`endif
      end
   endtask

   // Plain per-class bit count over the flattened feature vector.
   task automatic model(output int ec, output int es);
      int s;
      ec = 0;
      es = 0;
      for (int c = 0; c < NC; c++) begin
         s = 0;
         for (int b = 0; b < FW; b++)
            if (img[b / P][b % P] == wts[c][b]) s++;
         s += int'(bias_v[c]);
         if (c == 0 || s > es) begin
            ec = c;
            es = s;
         end
      end
   endtask

   task automatic wait_ready(output int lat);
      int n;
      n   = 0;
      lat = -1;
      while (n < 400) begin
         @(posedge clk);
         #1;
         if (dout_rdy) begin
            lat = n;
            break;
         end
         n++;
      end
   endtask

   task automatic check_result(input string nm, input int lat,
                               input int ec, input int es);
      chk({nm, " latency"}, lat, LAT);
      chk({nm, " class"}, int'(cls_o), ec);
      chk({nm, " score"}, int'(score_o), es);
   endtask

   task automatic run_expect(input string nm, input int ec, input int es);
      int lat;
      @(negedge clk);
      din = 1'b1;
      wait_ready(lat);
      check_result(nm, lat, ec, es);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, " hold rdy"}, int'(dout_rdy), 1);
      chk({nm, " hold class"}, int'(cls_o), ec);
   endtask

   task automatic drop_check(input string nm);
      @(negedge clk);
      din = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, " drop rdy"}, int'(dout_rdy), 0);
      chk({nm, " drop class"}, int'(cls_o), 0);
      chk({nm, " drop score"}, int'(score_o), 0);
   endtask

   initial begin
      int lat;
      int ec;
      int es;

      vecs.push_back('{"w3zero", 1'b0, 1'b1, 3, 1'b0, 3, 1568});
      vecs.push_back('{"same0", 1'b0, 1'b0, -1, 1'b0, 0, 1568});
      vecs.push_back('{"same1", 1'b0, 1'b1, -1, 1'b0, 0, 0});
      vecs.push_back('{"padmask", 1'b1, 1'b1, -1, 1'b0, 0, 1568});
      vecs.push_back('{"w9one", 1'b1, 1'b0, 9, 1'b1, 9, 1568});
      vecs.push_back('{"w0best", 1'b1, 1'b0, 0, 1'b1, 0, 1568});

      fill(1'b0, 1'b0, -1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset rdy", int'(dout_rdy), 0);
      chk("reset class", int'(cls_o), 0);
      chk("reset score", int'(score_o), 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         fill(vecs[i].ffill, vecs[i].wfill, vecs[i].srow, vecs[i].sfill);
         run_expect(vecs[i].name, vecs[i].ecls, vecs[i].escore);
         drop_check(vecs[i].name);
      end

      // Drop data_in_ready mid-compute, then restart from scratch.
      fill(1'b0, 1'b1, 3, 1'b0);
      @(negedge clk);
      din = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      din = 1'b0;
      @(posedge clk);
      #1;
      chk("midrop rdy", int'(dout_rdy), 0);
      repeat (3) @(posedge clk);
      run_expect("midrop restart", 3, 1568);

      // Async reset in DONE clears outputs before the next edge.
      #2;
      rst = 1'b1;
      #1;
      chk("rst done rdy", int'(dout_rdy), 0);
      chk("rst done class", int'(cls_o), 0);
      chk("rst done score", int'(score_o), 0);
      #2;
      rst = 1'b0;
      wait_ready(lat);
      check_result("rst recover", lat, 3, 1568);
      drop_check("rst recover");

      // Async reset mid-ACCUM with data_in_ready held high.
      fill(1'b1, 1'b0, 6, 1'b1);
      @(negedge clk);
      din = 1'b1;
      repeat (30) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst accum rdy", int'(dout_rdy), 0);
      #2;
      rst = 1'b0;
      wait_ready(lat);
      check_result("rst accum recover", lat, 6, 1568);
      drop_check("rst accum recover");

      for (int t = 0; t < 6; t++) begin
         fill_rand();
         if (t == 5) wts[7] = wts[2];
         model(ec, es);
         run_expect($sformatf("rand%0d", t), ec, es);
         drop_check($sformatf("rand%0d", t));
      end

`ifdef DENSE_ARGMAX_BIAS_EN
      fill(1'b0, 1'b0, -1, 1'b0);
      for (int c = 0; c < NC; c++)
         for (int b = 0; b < 784; b++) wts[c][b] = 1'b1;
      bias_v[7] = 8'sd5;
      run_expect("bias7", 7, 789);
      drop_check("bias7");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
